// File: rtl/regfile_wb.sv
// regfile_wb: writeback unit driving the single register-file write port.
//   Merges ALU results (valid/ready) and load results (valid only, never
//   stalled). A load always wins the port. An ALU result that collides with a
//   load, or that arrives while older ALU results are still waiting, is queued
//   in an in-order FIFO. Per-register pending-write status is reported so the
//   issue stage can hold dependent instructions.
//
// Optional feature: define WB_BYPASS_EN to forward the in-flight write data
//   onto s1_out/s2_out. This covers the cycle where the register file is being
//   written but cannot yet be read. Without the macro the operands are a pure
//   pass-through of rf_s1/rf_s2.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   alu_valid/ready/rd/data       ALU result handshake
//   ld_valid/rd/data              load result, always accepted
//   wen, dsel, d                  registered register-file write port
//   q1_sel/q2_sel -> q1/q2_busy   combinational pending-write queries
//   rf_s1/s2, s1sel/s2sel         register-file read data and its selects
//   s1_out, s2_out                operands to the datapath
//
// FIFO state (derived from the entry count):
//   state  | meaning
//   EMPTY  | no queued ALU results
//   QUEUED | some, but not all, entries hold results
//   FULL   | every entry holds a result; alu_ready is low
module regfile_wb #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            wen,
  output logic [4:0]      dsel,
  output logic [XLEN-1:0] d,
  input  logic [4:0]      q1_sel,
  input  logic [4:0]      q2_sel,
  output logic            q1_busy,
  output logic            q2_busy,
  input  logic [XLEN-1:0] rf_s1,
  input  logic [XLEN-1:0] rf_s2,
  input  logic [4:0]      s1sel,
  input  logic [4:0]      s2sel,
  output logic [XLEN-1:0] s1_out,
  output logic [XLEN-1:0] s2_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {EMPTY, QUEUED, FULL} fifo_state_e;

  logic [4:0]      rd_mem_q   [DEPTH];
  logic [XLEN-1:0] data_mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            wen_q, wen_d;
  logic [4:0]      dsel_q, dsel_d;
  logic [XLEN-1:0] d_q, d_d;
  fifo_state_e     fifo_st;
  logic            alu_xfer, alu_keep, push, pop;
  logic            q1_hit, q2_hit;
  logic [AW-1:0]   off;

  always_comb begin
    fifo_st = QUEUED;
    if (count_q == '0)
      fifo_st = EMPTY;
    else if (count_q == CW'(DEPTH))
      fifo_st = FULL;
  end

  // Readiness is based on the registered count only; a same-cycle pop does
  // not free a slot for the incoming result.
  assign alu_ready = (fifo_st != FULL);
  assign alu_xfer  = alu_valid & alu_ready;
  // Results for x0 complete their handshake but are dropped here.
  assign alu_keep  = alu_xfer & (alu_rd != 5'd0);

  always_comb begin
    wen_d  = 1'b0;
    dsel_d = dsel_q;
    d_d    = d_q;
    push   = 1'b0;
    pop    = 1'b0;
    if (ld_valid) begin
      // A load to x0 still owns the port this cycle, but it writes nothing.
      if (ld_rd != 5'd0) begin
        wen_d  = 1'b1;
        dsel_d = ld_rd;
        d_d    = ld_data;
      end
      push = alu_keep;
    end else if (fifo_st != EMPTY) begin
      pop    = 1'b1;
      wen_d  = 1'b1;
      dsel_d = rd_mem_q[rd_ptr_q];
      d_d    = data_mem_q[rd_ptr_q];
      push   = alu_keep;
    end else if (alu_keep) begin
      wen_d  = 1'b1;
      dsel_d = alu_rd;
      d_d    = alu_data;
    end
  end

  assign wr_ptr_d = wr_ptr_q + AW'(push);
  assign rd_ptr_d = rd_ptr_q + AW'(pop);
  assign count_d  = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wen_q    <= 1'b0;
      dsel_q   <= '0;
      d_q      <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wen_q    <= wen_d;
      dsel_q   <= dsel_d;
      d_q      <= d_d;
    end
  end

  // Storage has no reset; entries are only observed while inside the count.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[wr_ptr_q]   <= alu_rd;
      data_mem_q[wr_ptr_q] <= alu_data;
    end
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    q1_hit = 1'b0;
    q2_hit = 1'b0;
    off    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd_ptr_q;
      if ({1'b0, off} < count_q) begin
        if (rd_mem_q[i] == q1_sel) q1_hit = 1'b1;
        if (rd_mem_q[i] == q2_sel) q2_hit = 1'b1;
      end
    end
  end

  assign q1_busy = (q1_sel != 5'd0) & (q1_hit | (wen_q & (dsel_q == q1_sel)));
  assign q2_busy = (q2_sel != 5'd0) & (q2_hit | (wen_q & (dsel_q == q2_sel)));

  assign wen  = wen_q;
  assign dsel = dsel_q;
  assign d    = d_q;

`ifdef WB_BYPASS_EN
  assign s1_out = (wen_q && (dsel_q == s1sel) && (dsel_q != 5'd0)) ? d_q : rf_s1;
  assign s2_out = (wen_q && (dsel_q == s2sel) && (dsel_q != 5'd0)) ? d_q : rf_s2;
`else
  logic unused_sel;
  assign unused_sel = ^{s1sel, s2sel};
  assign s1_out = rf_s1;
  assign s2_out = rf_s2;
`endif

endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb: directed and randomized bench for regfile_wb. A queue-based
// model of the writeback rules predicts the outputs, and a compare process
// checks them every cycle. Directed sequences also pin literal values.
module tb_regfile_wb;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

`ifdef WB_BYPASS_EN
  localparam logic [XLEN-1:0] BYP_EXP = 32'h12345678;
`else
  localparam logic [XLEN-1:0] BYP_EXP = 32'h0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n = 1'b0;
  logic            alu_valid = 1'b0, alu_ready;
  logic [4:0]      alu_rd = '0;
  logic [XLEN-1:0] alu_data = '0;
  logic            ld_valid = 1'b0;
  logic [4:0]      ld_rd = '0;
  logic [XLEN-1:0] ld_data = '0;
  logic            wen;
  logic [4:0]      dsel;
  logic [XLEN-1:0] d;
  logic [4:0]      q1_sel = '0, q2_sel = '0;
  logic            q1_busy, q2_busy;
  logic [XLEN-1:0] rf_s1 = '0, rf_s2 = '0;
  logic [4:0]      s1sel = '0, s2sel = '0;
  logic [XLEN-1:0] s1_out, s2_out;

  regfile_wb #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
    .wen(wen), .dsel(dsel), .d(d),
    .q1_sel(q1_sel), .q2_sel(q2_sel), .q1_busy(q1_busy), .q2_busy(q2_busy),
    .rf_s1(rf_s1), .rf_s2(rf_s2), .s1sel(s1sel), .s2sel(s2sel),
    .s1_out(s1_out), .s2_out(s2_out)
  );

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t            mq[$];
  logic            m_wen  = 1'b0;
  logic [4:0]      m_dsel = '0;
  logic [XLEN-1:0] m_d    = '0;
  int              total  = 0;
  int              bad    = 0;
  bit              chk_en = 1'b0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_busy(input logic [4:0] sel);
    logic hit;
    hit = 1'b0;
    if (sel == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].rd == sel) hit = 1'b1;
    return hit | (m_wen && m_dsel == sel);
  endfunction

  function automatic logic [XLEN-1:0] m_opnd(input logic [4:0] sel, input logic [XLEN-1:0] rf);
`ifdef WB_BYPASS_EN
    if (m_wen && sel != 5'd0 && m_dsel == sel) return m_d;
`else
    if (sel == 5'd31 && 1'b0) return m_d;
`endif
    return rf;
  endfunction

  // Reference model: one write per cycle, load first, then oldest queued ALU
  // result, then a fresh ALU result; extra ALU results join the queue tail.
  always @(posedge clk or negedge rst_n) begin
    bit   xfer, keep;
    ent_t e;
    if (!rst_n) begin
      mq.delete();
      m_wen  = 1'b0;
      m_dsel = '0;
      m_d    = '0;
    end else begin
      xfer = alu_valid && (mq.size() < DEPTH);
      keep = xfer && (alu_rd != 5'd0);
      if (ld_valid) begin
        m_wen = (ld_rd != 5'd0);
        if (ld_rd != 5'd0) begin
          m_dsel = ld_rd;
          m_d    = ld_data;
        end
      end else if (mq.size() > 0) begin
        e      = mq.pop_front();
        m_wen  = 1'b1;
        m_dsel = e.rd;
        m_d    = e.data;
      end else if (keep) begin
        m_wen  = 1'b1;
        m_dsel = alu_rd;
        m_d    = alu_data;
        keep   = 1'b0;
      end else begin
        m_wen = 1'b0;
      end
      if (keep) begin
        e.rd   = alu_rd;
        e.data = alu_data;
        mq.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      chk("wen", wen, m_wen);
      chk("dsel", dsel, m_dsel);
      chk("d", d, m_d);
      chk("alu_ready", alu_ready, mq.size() != DEPTH);
      chk("q1_busy", q1_busy, m_busy(q1_sel));
      chk("q2_busy", q2_busy, m_busy(q2_sel));
      chk("s1_out", s1_out, m_opnd(s1sel, rf_s1));
      chk("s2_out", s2_out, m_opnd(s2sel, rf_s2));
    end
  end

  task automatic step(input logic av, input logic [4:0] ard, input logic [XLEN-1:0] adat,
                      input logic lv, input logic [4:0] lrd, input logic [XLEN-1:0] ldat);
    @(negedge clk);
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = adat;
    ld_valid  = lv;
    ld_rd     = lrd;
    ld_data   = ldat;
    #3;
  endtask

  initial begin
    int ld_pct;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #3;
    chk_en = 1'b1;
    chk("rst_wen", wen, 0);
    chk("rst_dsel", dsel, 0);
    chk("rst_d", d, 0);
    chk("rst_ready", alu_ready, 1);

    // ALU alone
    step(1, 5, 32'hDEADBEEF, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("alu_wen", wen, 1);
    chk("alu_dsel", dsel, 5);
    chk("alu_d", d, 32'hDEADBEEF);

    // Collision: load first, queued ALU result next
    q1_sel = 5'd7;
    step(1, 7, 32'h77, 1, 3, 32'h33);
    step(0, 0, 0, 0, 0, 0);
    chk("col1_dsel", dsel, 3);
    chk("col1_d", d, 32'h33);
    chk("col1_busy7", q1_busy, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("col2_wen", wen, 1);
    chk("col2_dsel", dsel, 7);
    chk("col2_d", d, 32'h77);
    chk("col2_busy7", q1_busy, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("col3_wen", wen, 0);
    chk("col3_busy7", q1_busy, 0);

    // Fill: load held six cycles, ALU offered each cycle
    for (int i = 0; i < 6; i++) begin
      step(1, 5'(10 + i), 32'hA0 + i, 1, 5'(20 + i), 32'h200 + i);
      chk("fill_ready", alu_ready, (i < 4));
    end
    step(0, 0, 0, 0, 0, 0);
    chk("fill_ld_dsel", dsel, 25);
    chk("fill_ld_d", d, 32'h205);
    for (int j = 0; j < 4; j++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("drain_wen", wen, 1);
      chk("drain_dsel", dsel, 10 + j);
      chk("drain_d", d, 32'hA0 + j);
    end
    step(0, 0, 0, 0, 0, 0);
    chk("drain_end_wen", wen, 0);
    chk("drain_end_ready", alu_ready, 1);

    // Results for x0
    step(1, 0, 1, 0, 0, 0);
    chk("x0_ready", alu_ready, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("x0_wen", wen, 0);
    chk("x0_ready_after", alu_ready, 1);

    // Operand forwarding of the in-flight write
    s1sel = 5'd9;
    rf_s1 = '0;
    step(1, 9, 32'h12345678, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("byp_wen", wen, 1);
    chk("byp_dsel", dsel, 9);
    chk("byp_s1", s1_out, BYP_EXP);

    // Reset with two results queued
    q1_sel = 5'd11;
    step(1, 11, 32'hB1, 1, 1, 32'h1);
    step(1, 12, 32'hB2, 1, 2, 32'h2);
    @(negedge clk);
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    rst_n     = 1'b0;
    #3;
    chk("mrst_wen", wen, 0);
    chk("mrst_ready", alu_ready, 1);
    chk("mrst_busy", q1_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("mrst_nowrite", wen, 0);
    end

    // Randomized traffic with alternating load pressure
    for (int n = 0; n < 3000; n++) begin
      ld_pct = ((n / 500) % 2 == 1) ? 70 : 20;
      @(negedge clk);
      rst_n     = ($urandom_range(0, 299) != 0);
      alu_valid = ($urandom_range(0, 99) < 60);
      alu_rd    = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      ld_valid  = ($urandom_range(0, 99) < ld_pct);
      ld_rd     = 5'($urandom_range(0, 7));
      ld_data   = $urandom;
      q1_sel    = 5'($urandom_range(0, 7));
      q2_sel    = 5'($urandom_range(0, 7));
      s1sel     = 5'($urandom_range(0, 7));
      s2sel     = 5'($urandom_range(0, 7));
      rf_s1     = $urandom;
      rf_s2     = $urandom;
    end

    @(negedge clk);
    #3;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
